fft_bfly_stream_pe: RTL and testbench
=====================================

Name: fft_bfly_stream_pe

Overview:
- Streaming radix-2 DIF butterfly processing element for the FFT datapath.
- Accepts complex (a, b) pairs, each with its own twiddle factor W, and buffers them in an internal FIFO of DEPTH entries.
- Produces A = a+b and B = (a−b)·W through a 3-stage pipeline, with rounding, optional divide-by-2 scaling, saturation and valid/ready backpressure on both sides.
- Replaces the fixed 8-pair, 16-bit, three-cycles-per-pair butterfly with a parametrised block sustaining one pair per cycle.

Parameters:
- DW, 16, signed width of each real/imag component.
- TW, 16, signed width of each twiddle component.
- TFRAC, 14, fraction bits of the twiddle (0x4000 = +1.0 at defaults).
- DEPTH, 8, input FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- in_valid  in  1  input pair valid
- in_ready  out  1  FIFO can accept
- in_a  in  2*DW  a: [2DW-1:DW] real, [DW-1:0] imag
- in_b  in  2*DW  b, same packing
- in_w  in  2*TW  twiddle: [2TW-1:TW] real, [TW-1:0] imag
- in_last  in  1  last pair of frame
- scale  in  1  1 = halve both outputs; sampled with each pair
- out_valid  out  1  output pair valid
- out_ready  in  1  downstream accepts
- out_a  out  2*DW  A, same packing
- out_b  out  2*DW  B, same packing
- out_last  out  1  last flag of output pair
- ovf  out  1  sticky saturation flag
- frame_cnt  out  16  completed output frames

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk.
  - On reset: FIFO emptied, all pipeline valids cleared, out_a=out_b=0, out_valid=0, out_last=0, ovf=0, frame_cnt=0.
  - in_ready=0 while rst is high and 1 after reset (FIFO empty).
- Input handshake:
  - A pair (with w, last, scale) is pushed on an edge where in_valid && in_ready.
  - in_ready = !fifo_full, driven combinationally from the registered count.
  - When full, a push is refused even if a pop occurs on the same edge.
- Pipeline enable:
  - en = !out_valid || out_ready. All stages advance together when en=1 and hold when en=0.
  - A FIFO pop occurs when en && !fifo_empty; the popped entry loads S1.
  - An empty FIFO inserts a bubble (S1 valid=0).
- S1 (sum/difference, DW+1 bits each):
  - sr = ar+br, si = ai+bi
  - dr = ar−br, di = ai−bi
- S2 (complex multiply, full precision):
  - pr = dr·wr − di·wi
  - pi = dr·wi + di·wr
  - sr/si, last and scale are carried alongside.
- S3 / output register:
  - B components: shift = TFRAC + scale. A components: shift = scale.
  - Round half-up: add 2^(shift−1) when shift>0, then arithmetic right shift.
  - Saturate to [−2^(DW−1), 2^(DW−1)−1]. Any clipped component sets ovf=1; ovf is cleared only by rst.
- Latency and throughput:
  - A pair accepted on edge k, with no stall and an empty FIFO, appears with out_valid=1 after edge k+3.
  - Throughput is 1 pair per cycle.
  - Order is strictly preserved; no pair is dropped or duplicated under any in/out handshake pattern.
- Output:
  - out_* hold stable while out_valid && !out_ready.
  - out_valid clears on the accepting edge when no new valid data enters S3.
- frame_cnt increments on each edge with out_valid && out_ready && out_last, wrapping 0xFFFF→0.
- Capacity: with out_ready=0, the block holds DEPTH + 3 pairs in flight.
- Reset mid-operation: all in-flight pairs are discarded; no partial outputs after rst deasserts.

Test Plan:
1. W=(0x4000,0), a=(100,50), b=(20,10), scale=0 → out_a=(120,60), out_b=(80,40), out_valid 3 edges after accept.
2. W=(0,0xC000) (−j), same a/b → out_a=(120,60), out_b=(40,−80); then scale=1 → out_a=(60,30), out_b=(20,−40).
3. a=(0x7FFF,0), b=(1,0), W=1.0, scale=0 → out_a real=0x7FFF (saturated), ovf=1 and stays 1; out_b=(0x7FFE,0).
4. Continuous in_valid, out_ready=0 → exactly 11 pairs accepted then in_ready=0; set out_ready=1 → the 11 pairs emerge in order, back-to-back, no loss or duplicate.
5. Two frames of 4 pairs, last on pairs 4 and 8, random out_ready toggling → out_last on output 4 and 8, frame_cnt=2.
6. Assert rst with 5 pairs in flight → out_valid=0, ovf=0, frame_cnt=0, in_ready=1 after release; next pair behaves as in test 1.

Source files
------------

// File: rtl/fft_bfly_stream_pe.sv
// Streaming radix-2 DIF butterfly processing element.
// Pairs (a, b) with their own twiddle W are buffered in a DEPTH-entry FIFO. A 3-stage
// pipeline produces A = a + b and B = (a - b) * W. Both outputs are rounded half-up,
// optionally halved, and saturated. One pair per cycle is sustained.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     input handshake; in_a, in_b, in_w, in_last, scale travel together
//   out_valid/out_ready   output handshake; out_a, out_b, out_last
//   ovf                   sticky saturation flag, cleared only by rst
//   frame_cnt             count of completed output frames (out_last accepted)
module fft_bfly_stream_pe #(
    parameter int unsigned DW    = 16,
    parameter int unsigned TW    = 16,
    parameter int unsigned TFRAC = 14,
    parameter int unsigned DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2*DW-1:0] in_a,
    input  logic [2*DW-1:0] in_b,
    input  logic [2*TW-1:0] in_w,
    input  logic            in_last,
    input  logic            scale,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [2*DW-1:0] out_a,
    output logic [2*DW-1:0] out_b,
    output logic            out_last,
    output logic            ovf,
    output logic [15:0]     frame_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned EW = 4*DW + 2*TW + 2;
    localparam int unsigned PW = DW + TW + 2;   // full-precision complex product
    localparam int unsigned XW = PW + 1;        // headroom for the rounding add
    localparam logic signed [XW-1:0] MAXV = {{(XW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [XW-1:0] MINV = ~MAXV;

    // ---------------- input FIFO ----------------
    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          fifo_full, fifo_empty, push, pop, en;
    logic [EW-1:0] rd_data;

    assign fifo_full  = (count == (AW+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign in_ready   = !rst && !fifo_full;
    assign en         = !out_valid || out_ready;
    assign push       = in_valid && in_ready;
    assign pop        = en && !fifo_empty;
    assign rd_data    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {in_a, in_b, in_w, in_last, scale};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
        end
    end

    // ---------------- S1: sum / difference ----------------
    logic [2*DW-1:0]       ra, rb;
    logic signed [DW:0]    ar, ai, br, bi;
    logic                  s1_valid, s1_last, s1_scale;
    logic signed [DW:0]    s1_sr, s1_si, s1_dr, s1_di;
    logic [2*TW-1:0]       s1_w;

    assign ra = rd_data[EW-1 -: 2*DW];
    assign rb = rd_data[EW-2*DW-1 -: 2*DW];
    assign ar = {ra[2*DW-1], ra[2*DW-1:DW]};
    assign ai = {ra[DW-1], ra[DW-1:0]};
    assign br = {rb[2*DW-1], rb[2*DW-1:DW]};
    assign bi = {rb[DW-1], rb[DW-1:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_sr    <= '0;
            s1_si    <= '0;
            s1_dr    <= '0;
            s1_di    <= '0;
            s1_w     <= '0;
            s1_last  <= 1'b0;
            s1_scale <= 1'b0;
        end else if (en) begin
            s1_valid <= !fifo_empty;
            if (!fifo_empty) begin
                s1_sr    <= ar + br;
                s1_si    <= ai + bi;
                s1_dr    <= ar - br;
                s1_di    <= ai - bi;
                s1_w     <= rd_data[2*TW+1:2];
                s1_last  <= rd_data[1];
                s1_scale <= rd_data[0];
            end
        end
    end

    // ---------------- S2: complex multiply ----------------
    logic signed [PW-1:0] dr_x, di_x, wr_x, wi_x, pr, pi;
    logic                 s2_valid, s2_last, s2_scale;
    logic signed [PW-1:0] s2_pr, s2_pi;
    logic signed [DW:0]   s2_sr, s2_si;

    always_comb begin
        dr_x = {{(PW-DW-1){s1_dr[DW]}}, s1_dr};
        di_x = {{(PW-DW-1){s1_di[DW]}}, s1_di};
        wr_x = {{(PW-TW){s1_w[2*TW-1]}}, s1_w[2*TW-1:TW]};
        wi_x = {{(PW-TW){s1_w[TW-1]}}, s1_w[TW-1:0]};
        pr   = dr_x * wr_x - di_x * wi_x;
        pi   = dr_x * wi_x + di_x * wr_x;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            s2_pr    <= '0;
            s2_pi    <= '0;
            s2_sr    <= '0;
            s2_si    <= '0;
            s2_last  <= 1'b0;
            s2_scale <= 1'b0;
        end else if (en) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_pr    <= pr;
                s2_pi    <= pi;
                s2_sr    <= s1_sr;
                s2_si    <= s1_si;
                s2_last  <= s1_last;
                s2_scale <= s1_scale;
            end
        end
    end

    // ---------------- S3: round, scale, saturate ----------------
    function automatic logic [DW-1:0] round_sat(input logic signed [XW-1:0] v,
                                                input int unsigned sh, output logic clip);
        logic signed [XW-1:0] r;
        r = v;
        if (sh > 0) r = v + (XW'(1) << (sh - 1));
        r = r >>> sh;
        clip = (r > MAXV) || (r < MINV);
        if (r > MAXV)      return MAXV[DW-1:0];
        else if (r < MINV) return MINV[DW-1:0];
        else               return r[DW-1:0];
    endfunction

    int unsigned          sha, shb;
    logic [3:0]           clip;
    logic [DW-1:0]        nxt_ar, nxt_ai, nxt_br, nxt_bi;

    always_comb begin
        sha    = {31'b0, s2_scale};
        shb    = TFRAC + sha;
        clip   = '0;
        nxt_ar = round_sat({{(XW-DW-1){s2_sr[DW]}}, s2_sr}, sha, clip[0]);
        nxt_ai = round_sat({{(XW-DW-1){s2_si[DW]}}, s2_si}, sha, clip[1]);
        nxt_br = round_sat({s2_pr[PW-1], s2_pr}, shb, clip[2]);
        nxt_bi = round_sat({s2_pi[PW-1], s2_pi}, shb, clip[3]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_a     <= '0;
            out_b     <= '0;
            out_last  <= 1'b0;
            ovf       <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (en) begin
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_a    <= {nxt_ar, nxt_ai};
                    out_b    <= {nxt_br, nxt_bi};
                    out_last <= s2_last;
                    if (|clip) ovf <= 1'b1;
                end
            end
            if (out_valid && out_ready && out_last) frame_cnt <= frame_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_fft_bfly_stream_pe.sv
// Self-checking bench for fft_bfly_stream_pe: a driver pushes expected results into a
// queue on every accepted pair; a forked monitor pops and compares on every output handshake.
module tb_fft_bfly_stream_pe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, scale;
    logic [31:0] in_a, in_b, in_w;
    logic        out_valid, out_ready, out_last, ovf;
    logic [31:0] out_a, out_b;
    logic [15:0] frame_cnt;

    fft_bfly_stream_pe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_w      (in_w),
        .in_last   (in_last),
        .scale     (scale),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_last  (out_last),
        .ovf       (ovf),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        last;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic rnd_mode = 1'b0;

    localparam logic [31:0] W_ONE  = {16'sd16384, 16'sd0};
    localparam logic [31:0] W_NEGJ = {16'sd0, -16'sd16384};

    function automatic logic [31:0] cx(input int re, input int im);
        logic [31:0] r;
        r = {re[15:0], im[15:0]};
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_output got a=%h b=%h", out_a, out_b);
                end else begin
                    e = q.pop_front();
                    total++;
                    if ({out_a, out_b, out_last} !== {e.a, e.b, e.last}) begin
                        bad++;
                        $display("FAIL out_pair got a=%h b=%h last=%b exp a=%h b=%h last=%b",
                                 out_a, out_b, out_last, e.a, e.b, e.last);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] w,
                        input logic last, input logic sc,
                        input logic [31:0] ea, input logic [31:0] eb);
        logic rdy;
        int   n;
        rdy = 1'b0;
        n   = 0;
        in_a = a; in_b = b; in_w = w; in_last = last; scale = sc; in_valid = 1'b1;
        while (!rdy && n < 100) begin
            @(negedge clk);
            rdy = in_ready;
            step();
            n++;
        end
        if (rdy) q.push_back('{a: ea, b: eb, last: last});
        else chk("send_timeout", 64'(rdy), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 400) begin
            step();
            n++;
        end
        rnd_mode  = 1'b0;
        out_ready = 1'b1;
        repeat (2) step();
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    // Checks latency for test 1's pair: out_valid must rise exactly after edge k+3.
    task automatic test_basic(input string tag);
        send(cx(100, 50), cx(20, 10), W_ONE, 1'b0, 1'b0, cx(120, 60), cx(80, 40));
        repeat (3) @(negedge clk);
        chk({tag, "_lat_k2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        chk({tag, "_lat_k3"}, 64'(out_valid), 64'd1);
        drain();
    endtask

    initial begin
        int acc;
        rst = 1'b1; in_valid = 1'b0; in_last = 1'b0; scale = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_w = '0;
        fork
            monitor();
        join_none

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("rst_out_ab", {out_a, out_b}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);
        step();

        // Test 1: W = 1.0
        test_basic("t1");

        // Test 2: W = -j, unscaled then halved
        send(cx(100, 50), cx(20, 10), W_NEGJ, 1'b0, 1'b0, cx(120, 60), cx(40, -80));
        send(cx(100, 50), cx(20, 10), W_NEGJ, 1'b0, 1'b1, cx(60, 30), cx(20, -40));
        drain();
        chk("t2_ovf_clear", 64'(ovf), 64'd0);

        // Test 3: saturation of A
        send(cx(32767, 0), cx(1, 0), W_ONE, 1'b0, 1'b0, cx(32767, 0), cx(32766, 0));
        drain();
        chk("t3_ovf_set", 64'(ovf), 64'd1);

        // Test 4: capacity with out_ready low, then back-to-back drain
        out_ready = 1'b0;
        acc = 0;
        in_w = W_ONE; in_last = 1'b0; scale = 1'b0; in_b = cx(7, 3);
        for (int i = 0; i < 16; i++) begin
            in_a = cx(100 * acc, -acc);
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) begin
                q.push_back('{a: cx(100 * acc + 7, 3 - acc), b: cx(100 * acc - 7, -acc - 3),
                              last: 1'b0});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t4_accepted", 64'(acc), 64'd11);
        chk("t4_in_ready_full", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            chk("t4_back_to_back", 64'(out_valid), 64'd1);
        end
        @(negedge clk);
        chk("t4_done_valid", 64'(out_valid), 64'd0);
        drain();
        chk("t4_ovf_sticky", 64'(ovf), 64'd1);
        chk("t4_frame_cnt", 64'(frame_cnt), 64'd0);

        // Test 5: two frames with random backpressure
        rnd_mode = 1'b1;
        for (int f = 0; f < 2; f++) begin
            for (int j = 0; j < 4; j++) begin
                int k;
                k = 20 + 4 * f + j;
                send(cx(k, 2 * k), cx(5, 1), W_ONE, 1'(j == 3), 1'b0,
                     cx(k + 5, 2 * k + 1), cx(k - 5, 2 * k - 1));
            end
        end
        drain();
        chk("t5_frame_cnt", 64'(frame_cnt), 64'd2);

        // Test 6: reset with pairs in flight
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(cx(i, i), cx(1, 1), W_ONE, 1'b0, 1'b0, cx(i + 1, i + 1), cx(i - 1, i - 1));
        repeat (2) step();
        rst = 1'b1;
        q.delete();
        @(negedge clk);
        chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
        chk("t6_rst_ovf", 64'(ovf), 64'd0);
        chk("t6_rst_frame_cnt", 64'(frame_cnt), 64'd0);
        chk("t6_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t6_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t6_no_stale_out", 64'(out_valid), 64'd0);
        end
        step();
        test_basic("t6");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
